// File: rtl/mioc_chk_pkg.sv
// Shared types and constants for the MIOC gate checker.
// Optional feature macro: MIOC_CHK_SIG_EN (response signature MISR).
package mioc_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } chk_state_t;

  localparam int PAT_W = 4;

  // x^16 + x^12 + x^3 + x + 1 ; the x^16 term is implied by the shift-out bit
  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(input logic [15:0] cur,
                                            input logic [PAT_W:0] din);
    misr_step = {cur[14:0], 1'b0}
              ^ (cur[15] ? MISR_POLY : 16'h0000)
              ^ {{(15 - PAT_W){1'b0}}, din};
  endfunction

endpackage

// File: rtl/mioc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Resets to 0 asynchronously on an active-high reset.
module mioc_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mioc_gate_checker.sv
// Stimulus sequencer and response checker for a single MIOC gate under test.
// Optional feature macro: MIOC_CHK_SIG_EN adds the 16-bit response MISR and the sig port.
module mioc_gate_checker
  import mioc_chk_pkg::*;
#(
  parameter  int N_PAT      = 16,
  parameter  int SETTLE_CYC = 4,
  parameter  int ERR_W      = 8,
  localparam int FF_W       = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_data,
  input  logic             pat_exp,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             in4,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [FF_W-1:0]  first_fail
`ifdef MIOC_CHK_SIG_EN
  ,
  output logic [15:0]      sig
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYC);
  localparam logic [FF_W-1:0]  LAST_IDX    = FF_W'(N_PAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  chk_state_t       state_q;
  logic [FF_W-1:0]  idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             exp_q;
  logic [PAT_W-1:0] drive_q;
  logic [ERR_W-1:0] err_q;
  logic [FF_W-1:0]  ff_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             z_sync;
  logic             mismatch;
  logic [ERR_W-1:0] err_d;
`ifdef MIOC_CHK_SIG_EN
  logic [15:0]      misr_q;
`endif

  mioc_sync2 u_z_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (z),
    .q_o   (z_sync)
  );

  always_comb begin
    mismatch = z_sync ^ exp_q;
    err_d    = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // The run sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      drive_q <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef MIOC_CHK_SIG_EN
      misr_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_FETCH;
            idx_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef MIOC_CHK_SIG_EN
            misr_q  <= MISR_SEED;
`endif
          end
        end
        ST_FETCH: begin
          if (pat_valid) begin
            drive_q <= pat_data;
            exp_q   <= pat_exp;
            cnt_q   <= SETTLE_LOAD;
            ready_q <= 1'b0;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          err_q <= err_d;
          // err_q is still zero only if no earlier pattern of this run failed
          if (mismatch && (err_q == '0)) begin
            ff_q <= idx_q;
          end
`ifdef MIOC_CHK_SIG_EN
          misr_q <= misr_step(misr_q, {z_sync, drive_q});
`endif
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            idx_q   <= idx_q + FF_W'(1);
            ready_q <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pat_ready  = ready_q;
  assign in1        = drive_q[0];
  assign in2        = drive_q[1];
  assign in3        = drive_q[2];
  assign in4        = drive_q[3];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign first_fail = ff_q;
`ifdef MIOC_CHK_SIG_EN
  assign sig        = misr_q;
`endif

endmodule

// File: tb/tb_mioc_gate_checker.sv
// Self-checking bench for mioc_gate_checker: a 4-pattern and a 300-pattern instance
// driven by a host model, checked against a pattern-level reference model.
module tb_mioc_gate_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       startA, startB;
  logic [3:0] patData;
  logic       patExp, patValid;
  logic       sel;

  logic       aReady, aIn1, aIn2, aIn3, aIn4, aBusy, aDone, aPass, zA;
  logic [7:0] aErr;
  logic [1:0] aFirst;
  logic       bReady, bIn1, bIn2, bIn3, bIn4, bBusy, bDone, bPass, zB;
  logic [7:0] bErr;
  logic [8:0] bFirst;
`ifdef MIOC_CHK_SIG_EN
  logic [15:0] aSig, bSig, sigSel;
`endif

  int gateMode;
  int flipIdx;
  int appliedIdx;
  int nCompared;
  int nMismatched;

  logic [3:0] pats[300];
  logic       exps[300];

  function automatic logic gateZ(input int mode, input logic [3:0] p);
    case (mode)
      1:       gateZ = 1'b0;
      2:       gateZ = 1'b1;
      default: gateZ = ~p[0];
    endcase
  endfunction

  assign zA = gateZ(gateMode, {aIn4, aIn3, aIn2, aIn1}) ^ (flipIdx >= 0 && appliedIdx == flipIdx);
  assign zB = gateZ(gateMode, {bIn4, bIn3, bIn2, bIn1}) ^ (flipIdx >= 0 && appliedIdx == flipIdx);

  mioc_gate_checker #(.N_PAT(4), .SETTLE_CYC(4), .ERR_W(8)) dutA (
    .clk(clk), .rst(rst), .start(startA), .pat_data(patData), .pat_exp(patExp),
    .pat_valid(patValid), .pat_ready(aReady), .in1(aIn1), .in2(aIn2), .in3(aIn3),
    .in4(aIn4), .z(zA), .busy(aBusy), .done(aDone), .pass(aPass), .err_cnt(aErr),
    .first_fail(aFirst)
`ifdef MIOC_CHK_SIG_EN
    , .sig(aSig)
`endif
  );

  mioc_gate_checker #(.N_PAT(300), .SETTLE_CYC(4), .ERR_W(8)) dutB (
    .clk(clk), .rst(rst), .start(startB), .pat_data(patData), .pat_exp(patExp),
    .pat_valid(patValid), .pat_ready(bReady), .in1(bIn1), .in2(bIn2), .in3(bIn3),
    .in4(bIn4), .z(zB), .busy(bBusy), .done(bDone), .pass(bPass), .err_cnt(bErr),
    .first_fail(bFirst)
`ifdef MIOC_CHK_SIG_EN
    , .sig(bSig)
`endif
  );

  wire       rdy    = sel ? bReady : aReady;
  wire       bsy    = sel ? bBusy  : aBusy;
  wire       dn     = sel ? bDone  : aDone;
  wire       pss    = sel ? bPass  : aPass;
  wire [7:0] errSel = sel ? bErr   : aErr;
  wire [9:0] firstSel = sel ? {1'b0, bFirst} : {8'b0, aFirst};
  wire [3:0] inSel  = sel ? {bIn4, bIn3, bIn2, bIn1} : {aIn4, aIn3, aIn2, aIn1};
`ifdef MIOC_CHK_SIG_EN
  assign sigSel = sel ? bSig : aSig;
`endif

  initial forever #5 clk = ~clk;

  // Pattern-level model: which patterns mismatch, straight from the gate rule.
  task automatic model(input int n, output int expErr, output int expFirst, output bit expPass);
    int cnt;
    int first;
    logic zv;
    cnt = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      zv = gateZ(gateMode, pats[i]) ^ (i == flipIdx);
      if (zv != exps[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    expErr   = (cnt > 255) ? 255 : cnt;
    expFirst = (first < 0) ? 0 : first;
    expPass  = (cnt == 0);
  endtask

  // Host model: start a run, feed patterns on the handshake, optionally stall or abort.
  task automatic do_run(input int n, input int stallPat, input int stallCyc,
                        input int abortPat, output int cycles);
    int  edges, k, stalled, limit;
    bit  presented, prevRdy, firstIter, aborted;
    @(negedge clk);
    if (sel) startB = 1'b1; else startA = 1'b1;
    patValid = 1'b0;
    appliedIdx = -1;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    edges = 1; k = 0; stalled = 0; cycles = -1;
    presented = 1'b0; prevRdy = 1'b0; firstIter = 1'b1; aborted = 1'b0;
    limit = n * 6 + stallCyc + 50;
    while (edges < limit) begin
      if (presented && prevRdy) begin
        appliedIdx = k;
        k++;
      end
      if (firstIter) begin
        firstIter = 1'b0;
        nCompared++;
        if ({bsy, dn, rdy, errSel} !== {1'b1, 1'b0, 1'b1, 8'd0}) begin
          nMismatched++;
          $display("[TB] FAIL run_start: busy/done/ready/err = %b expected 1/0/1/0",
                   {bsy, dn, rdy, errSel});
        end
      end
      if (abortPat >= 0 && k == abortPat + 1 && !rdy) begin
        rst = 1'b1;
        #1;
        nCompared++;
        if ({rdy, inSel, bsy, dn, pss, errSel, firstSel} !== '0) begin
          nMismatched++;
          $display("[TB] FAIL reset_mid_run: outputs %h expected 0",
                   {rdy, inSel, bsy, dn, pss, errSel, firstSel});
        end
`ifdef MIOC_CHK_SIG_EN
        nCompared++;
        if (sigSel !== 16'h0) begin
          nMismatched++;
          $display("[TB] FAIL reset_mid_run_sig: got %h expected 0", sigSel);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (dn) begin
        cycles = edges;
        break;
      end
      if (k == stallPat && rdy && stalled < stallCyc) begin
        nCompared++;
        if (inSel !== pats[stallPat-1]) begin
          nMismatched++;
          $display("[TB] FAIL stall_hold: inputs %h expected %h", inSel, pats[stallPat-1]);
        end
        stalled++;
        patValid = 1'b0;
        presented = 1'b0;
      end else if (k < n) begin
        patData = pats[k];
        patExp = exps[k];
        patValid = 1'b1;
        presented = 1'b1;
      end else begin
        patValid = 1'b0;
        presented = 1'b0;
      end
      prevRdy = rdy;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    patValid = 1'b0;
    appliedIdx = -1;
    if (!aborted) begin
      nCompared++;
      if (cycles < 0) begin
        nMismatched++;
        $display("[TB] FAIL run_timeout: no done after %0d cycles, required within %0d", edges, limit);
      end
    end
  endtask

  // Compare a finished run against the model.
  task automatic check_result(input string name, input int n, input int cycles,
                              input int expCycles);
    int expErr, expFirst;
    bit expPass;
    model(n, expErr, expFirst, expPass);
    nCompared++;
    if (cycles !== expCycles) begin
      nMismatched++;
      $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", name, cycles, expCycles);
    end
    nCompared++;
    if (int'(errSel) !== expErr) begin
      nMismatched++;
      $display("[TB] FAIL %s_err_cnt: got %0d expected %0d", name, errSel, expErr);
    end
    nCompared++;
    if (int'(firstSel) !== expFirst) begin
      nMismatched++;
      $display("[TB] FAIL %s_first_fail: got %0d expected %0d", name, firstSel, expFirst);
    end
    nCompared++;
    if (pss !== expPass) begin
      nMismatched++;
      $display("[TB] FAIL %s_pass: got %b expected %b", name, pss, expPass);
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 4; i++) begin
      pats[i] = (i % 2 == 1) ? 4'h1 : 4'h0;
      exps[i] = (i % 2 == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({aReady, aIn4, aIn3, aIn2, aIn1, aBusy, aDone, aPass, aErr, aFirst} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_a: outputs nonzero %b",
               {aReady, aIn4, aIn3, aIn2, aIn1, aBusy, aDone, aPass, aErr, aFirst});
    end
    nCompared++;
    if ({bReady, bIn4, bIn3, bIn2, bIn1, bBusy, bDone, bPass, bErr, bFirst} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_b: outputs nonzero %b",
               {bReady, bIn4, bIn3, bIn2, bIn1, bBusy, bDone, bPass, bErr, bFirst});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_path();
    int cyc;
    sel = 1'b0; gateMode = 0; flipIdx = -1;
    load_basic();
    do_run(4, -1, 0, -1, cyc);
    check_result("good", 4, cyc, 25);
    repeat (5) @(negedge clk);
    nCompared++;
    if ({dn, pss, bsy} !== 3'b110) begin
      nMismatched++;
      $display("[TB] FAIL done_hold: done/pass/busy %b expected 110", {dn, pss, bsy});
    end
  endtask

  task automatic test_faulty_gate();
    int cyc;
    sel = 1'b0; gateMode = 1; flipIdx = -1;
    load_basic();
    do_run(4, -1, 0, -1, cyc);
    check_result("stuck0", 4, cyc, 25);
    nCompared++;
    if ({errSel, firstSel, pss} !== {8'd2, 10'd0, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL stuck0_fixed: err %0d first %0d pass %b expected 2 0 0",
               errSel, firstSel, pss);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    sel = 1'b0; gateMode = 0; flipIdx = -1;
    load_basic();
    do_run(4, 2, 10, -1, cyc);
    check_result("backpressure", 4, cyc, 35);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    sel = 1'b0; gateMode = 0; flipIdx = -1;
    load_basic();
    do_run(4, -1, 0, 2, cyc);
    do_run(4, -1, 0, -1, cyc);
    check_result("after_reset", 4, cyc, 25);
  endtask

  task automatic test_saturation();
    int cyc;
    sel = 1'b1; gateMode = 0; flipIdx = -1;
    for (int i = 0; i < 300; i++) begin
      pats[i] = 4'($urandom_range(0, 15));
      exps[i] = pats[i][0];
    end
    do_run(300, -1, 0, -1, cyc);
    check_result("saturate", 300, cyc, 1801);
    nCompared++;
    if (errSel !== 8'd255) begin
      nMismatched++;
      $display("[TB] FAIL saturate_fixed: err %0d expected 255", errSel);
    end
  endtask

  task automatic test_random();
    int cyc, sp, sc;
    sel = 1'b0; flipIdx = -1;
    for (int r = 0; r < 8; r++) begin
      gateMode = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        pats[i] = 4'($urandom_range(0, 15));
        exps[i] = 1'($urandom_range(0, 1));
      end
      sp = $urandom_range(1, 3);
      sc = $urandom_range(0, 5);
      do_run(4, sp, sc, -1, cyc);
      check_result("random_a", 4, cyc, 25 + sc);
    end
    sel = 1'b1; gateMode = 0;
    for (int i = 0; i < 300; i++) begin
      pats[i] = 4'($urandom_range(0, 15));
      exps[i] = 1'($urandom_range(0, 1));
    end
    sp = $urandom_range(1, 299);
    sc = $urandom_range(1, 8);
    do_run(300, sp, sc, -1, cyc);
    check_result("random_b", 300, cyc, 1801 + sc);
  endtask

`ifdef MIOC_CHK_SIG_EN
  task automatic test_signature();
    int cyc;
    logic [15:0] s1, s2, s3;
    sel = 1'b0; gateMode = 0; flipIdx = -1;
    load_basic();
    do_run(4, -1, 0, -1, cyc);
    s1 = sigSel;
    do_run(4, -1, 0, -1, cyc);
    s2 = sigSel;
    nCompared++;
    if (s1 === 16'h0 || s2 !== s1) begin
      nMismatched++;
      $display("[TB] FAIL sig_repeat: first %h second %h expected equal nonzero", s1, s2);
    end
    flipIdx = 2;
    do_run(4, -1, 0, -1, cyc);
    check_result("sig_flip", 4, cyc, 25);
    s3 = sigSel;
    flipIdx = -1;
    nCompared++;
    if (s3 === s1) begin
      nMismatched++;
      $display("[TB] FAIL sig_flip_differs: got %h expected different from %h", s3, s1);
    end
  endtask
`endif

  initial begin
    nCompared = 0; nMismatched = 0;
    startA = 1'b0; startB = 1'b0; patData = 4'h0; patExp = 1'b0; patValid = 1'b0;
    sel = 1'b0; gateMode = 0; flipIdx = -1; appliedIdx = -1;
    test_reset();
    test_good_path();
    test_faulty_gate();
    test_backpressure();
    test_reset_mid_run();
    test_saturation();
    test_random();
`ifdef MIOC_CHK_SIG_EN
    test_signature();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
